shadow_ram_arbiter: RTL and testbench

Arbitrates the shadow-ROM/RAM `block_ram` between two requesters.
- The Z80 snoop write path issues fire-and-forget write strobes and always has priority.
- The SPI host side issues single-byte read/write requests with a req/ack handshake.
- The block owns the RAM write port. It borrows the RAM read address only while the Z80 memory bus is idle.
- It sits between the Z80 bus decoder, the SPI register block and `block_ram`.

---
 rtl/shadow_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_shadow_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shadow_ram_arbiter.sv
// ---------------------------------------------------------------------------
// shadow_ram_arbiter
//
// Shares the shadow-ROM/RAM block_ram between two requesters:
//   * the Z80 snoop write path (fire-and-forget strobes, highest priority)
//   * the SPI host register block (single-byte req/ack reads and writes)
//
// This block owns the RAM write port. It takes over the RAM read address
// (through an external mux controlled by ram_rd_sel) only while the
// synchronized Z80 MREQ shows the memory bus idle.
//
// Ports
//   clk, rst_n                 system clock, asynchronous active-low reset
//   z80_wr_req/addr/data       one-cycle Z80 write strobe with address/data
//   z80_mreq_n                 raw asynchronous Z80 MREQ, synchronized here
//   spi_req/we/addr/wdata      level request, held until spi_ack
//   spi_ack                    one-cycle completion pulse
//   spi_rdata                  read data, valid with ack and held afterwards
//   ram_write_en/addr_w/din    registered RAM write port
//   ram_rd_sel, ram_addr_r     read-address mux select and SPI read address
//   ram_dout                   RAM read data, one-cycle synchronous latency
//   collisions                 saturating count of deferred/aborted requests
// ---------------------------------------------------------------------------
module shadow_ram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              z80_wr_req,
    input  logic [ADDR_W-1:0] z80_wr_addr,
    input  logic [DATA_W-1:0] z80_wr_data,
    input  logic              z80_mreq_n,

    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_ack,
    output logic [DATA_W-1:0] spi_rdata,

    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_addr_w,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd_sel,
    output logic [ADDR_W-1:0] ram_addr_r,
    input  logic [DATA_W-1:0] ram_dout,

    output logic [7:0]        collisions
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SWR  = 3'd1,
        ST_RADR = 3'd2,
        ST_RDAT = 3'd3,
        ST_REL  = 3'd4
    } state_t;

    localparam int SYNC_STAGES = 2;

    // -----------------------------------------------------------------------
    // MREQ synchronizer. Stages reset to 1 so the bus looks idle out of reset.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] mreq_sync_q;
    logic [SYNC_STAGES-1:0] mreq_sync_d;
    logic                   bus_idle;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_mreq_sync
            if (gi == 0) begin : g_first
                assign mreq_sync_d[gi] = z80_mreq_n;
            end else begin : g_chain
                assign mreq_sync_d[gi] = mreq_sync_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mreq_sync_q <= '1;
        end else begin
            mreq_sync_q <= mreq_sync_d;
        end
    end

    // Idle only when every stage agrees, so a single early high sample of a
    // recovering MREQ does not release the read port yet.
    assign bus_idle = &mreq_sync_q;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoded request conditions in IDLE.
    logic spi_wr_grant;
    logic spi_wr_blocked;
    logic spi_rd_grant;
    logic rd_abort;

    always_comb begin
        spi_wr_grant   = (state_q == ST_IDLE) && spi_req && spi_we && !z80_wr_req;
        spi_wr_blocked = (state_q == ST_IDLE) && spi_req && spi_we &&  z80_wr_req;
        spi_rd_grant   = (state_q == ST_IDLE) && spi_req && !spi_we && bus_idle;
        // The Z80 started a bus cycle while we were presenting our address:
        // give the read mux back and retry from IDLE.
        rd_abort       = (state_q == ST_RADR) && !bus_idle;
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (spi_wr_grant) begin
                    state_d = ST_SWR;
                end else if (spi_rd_grant) begin
                    state_d = ST_RADR;
                end
            end
            ST_SWR: begin
                state_d = ST_REL;
            end
            ST_RADR: begin
                state_d = rd_abort ? ST_IDLE : ST_RDAT;
            end
            ST_RDAT: begin
                state_d = ST_REL;
            end
            ST_REL: begin
                // Forces at least one low cycle of spi_req between transfers;
                // a requester that already dropped req leaves at once.
                if (!spi_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs (decoded from the registered state)
    // -----------------------------------------------------------------------
    logic              spi_ack_o;
    logic              ram_rd_sel_o;
    logic [ADDR_W-1:0] ram_addr_r_o;

    always_comb begin
        spi_ack_o    = 1'b0;
        ram_rd_sel_o = 1'b0;
        ram_addr_r_o = '0;
        case (state_q)
            ST_SWR: begin
                spi_ack_o = 1'b1;
            end
            ST_RADR: begin
                ram_rd_sel_o = 1'b1;
                ram_addr_r_o = spi_addr;
            end
            ST_RDAT: begin
                ram_rd_sel_o = 1'b1;
                ram_addr_r_o = spi_addr;
                spi_ack_o    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign spi_ack    = spi_ack_o;
    assign ram_rd_sel = ram_rd_sel_o;
    assign ram_addr_r = ram_addr_r_o;

    // -----------------------------------------------------------------------
    // Registered RAM write port. A Z80 strobe always wins; an SPI write is
    // only granted in a cycle without a Z80 strobe, so at most one write is
    // loaded per cycle and the Z80 path never waits.
    // -----------------------------------------------------------------------
    logic              ram_write_en_q;
    logic              ram_write_en_d;
    logic [ADDR_W-1:0] ram_addr_w_q;
    logic [ADDR_W-1:0] ram_addr_w_d;
    logic [DATA_W-1:0] ram_din_q;
    logic [DATA_W-1:0] ram_din_d;

    always_comb begin
        ram_write_en_d = 1'b0;
        ram_addr_w_d   = ram_addr_w_q;
        ram_din_d      = ram_din_q;
        if (z80_wr_req) begin
            ram_write_en_d = 1'b1;
            ram_addr_w_d   = z80_wr_addr;
            ram_din_d      = z80_wr_data;
        end else if (spi_wr_grant) begin
            ram_write_en_d = 1'b1;
            ram_addr_w_d   = spi_addr;
            ram_din_d      = spi_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_write_en_q <= 1'b0;
            ram_addr_w_q   <= '0;
            ram_din_q      <= '0;
        end else begin
            ram_write_en_q <= ram_write_en_d;
            ram_addr_w_q   <= ram_addr_w_d;
            ram_din_q      <= ram_din_d;
        end
    end

    assign ram_write_en = ram_write_en_q;
    assign ram_addr_w   = ram_addr_w_q;
    assign ram_din      = ram_din_q;

    // -----------------------------------------------------------------------
    // Read data. RAM data for the address shown in RADR arrives during RDAT,
    // the ack cycle, so it is passed straight through then and captured for
    // holding until the next completed read.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] spi_rdata_q;
    logic [DATA_W-1:0] spi_rdata_d;

    always_comb begin
        spi_rdata_d = spi_rdata_q;
        if (state_q == ST_RDAT) begin
            spi_rdata_d = ram_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_rdata_q <= '0;
        end else begin
            spi_rdata_q <= spi_rdata_d;
        end
    end

    assign spi_rdata = (state_q == ST_RDAT) ? ram_dout : spi_rdata_q;

    // -----------------------------------------------------------------------
    // Collision counter: deferred SPI writes and aborted SPI reads. Reads
    // waiting in IDLE for the bus are not counted.
    // -----------------------------------------------------------------------
    logic [7:0] collisions_q;
    logic [7:0] collisions_d;

    always_comb begin
        collisions_d = collisions_q;
        if ((spi_wr_blocked || rd_abort) && (collisions_q != 8'hFF)) begin
            collisions_d = collisions_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collisions_q <= 8'd0;
        end else begin
            collisions_q <= collisions_d;
        end
    end

    assign collisions = collisions_q;

endmodule

// File: tb/tb_shadow_ram_arbiter.sv
module tb_shadow_ram_arbiter;

    localparam int AW = 14;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          z80_wr_req;
    logic [AW-1:0] z80_wr_addr;
    logic [DW-1:0] z80_wr_data;
    logic          z80_mreq_n;
    logic          spi_req;
    logic          spi_we;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata;
    logic          spi_ack;
    logic [DW-1:0] spi_rdata;
    logic          ram_write_en;
    logic [AW-1:0] ram_addr_w;
    logic [DW-1:0] ram_din;
    logic          ram_rd_sel;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_dout;
    logic [7:0]    collisions;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shadow_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .z80_wr_req   (z80_wr_req),
        .z80_wr_addr  (z80_wr_addr),
        .z80_wr_data  (z80_wr_data),
        .z80_mreq_n   (z80_mreq_n),
        .spi_req      (spi_req),
        .spi_we       (spi_we),
        .spi_addr     (spi_addr),
        .spi_wdata    (spi_wdata),
        .spi_ack      (spi_ack),
        .spi_rdata    (spi_rdata),
        .ram_write_en (ram_write_en),
        .ram_addr_w   (ram_addr_w),
        .ram_din      (ram_din),
        .ram_rd_sel   (ram_rd_sel),
        .ram_addr_r   (ram_addr_r),
        .ram_dout     (ram_dout),
        .collisions   (collisions)
    );

    // Behavioural block_ram: read-first, one-cycle read latency, external
    // read-address mux (Z80 side address is 0 in this bench).
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] rd_addr;
    assign rd_addr = ram_rd_sel ? ram_addr_r : '0;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr_w] <= ram_din;
        ram_dout <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          zr;
        logic [AW-1:0] za;
        logic [DW-1:0] zd;
        logic          sr;
        logic          sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          eack;
        logic          ewen;
        logic [AW-1:0] ewa;
        logic [DW-1:0] ewd;
        logic          erd;
        logic [DW-1:0] erdata;
        logic [7:0]    ecoll;
    } vec_t;

    function automatic vec_t mkv(input logic zr, input logic [AW-1:0] za, input logic [DW-1:0] zd,
                                 input logic sr, input logic sw, input logic [AW-1:0] sa,
                                 input logic [DW-1:0] sd, input logic eack, input logic ewen,
                                 input logic [AW-1:0] ewa, input logic [DW-1:0] ewd,
                                 input logic erd, input logic [DW-1:0] erdata, input logic [7:0] ecoll);
        vec_t v;
        v.zr = zr; v.za = za; v.zd = zd; v.sr = sr; v.sw = sw; v.sa = sa; v.sd = sd;
        v.eack = eack; v.ewen = ewen; v.ewa = ewa; v.ewd = ewd;
        v.erd = erd; v.erdata = erdata; v.ecoll = ecoll;
        return v;
    endfunction

    vec_t vecs [28];

    // Drive one cycle of inputs, then compare outputs just after the edge.
    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        z80_wr_req  = v.zr;
        z80_wr_addr = v.za;
        z80_wr_data = v.zd;
        spi_req     = v.sr;
        spi_we      = v.sw;
        spi_addr    = v.sa;
        spi_wdata   = v.sd;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_ack", idx), {31'd0, spi_ack}, {31'd0, v.eack});
        check($sformatf("v%0d_wen", idx), {31'd0, ram_write_en}, {31'd0, v.ewen});
        if (v.ewen) begin
            check($sformatf("v%0d_waddr", idx), {18'd0, ram_addr_w}, {18'd0, v.ewa});
            check($sformatf("v%0d_wdata", idx), {24'd0, ram_din}, {24'd0, v.ewd});
        end
        check($sformatf("v%0d_rdsel", idx), {31'd0, ram_rd_sel}, {31'd0, v.erd});
        if (v.erd) check($sformatf("v%0d_raddr", idx), {18'd0, ram_addr_r}, {18'd0, v.sa});
        check($sformatf("v%0d_rdata", idx), {24'd0, spi_rdata}, {24'd0, v.erdata});
        check($sformatf("v%0d_coll", idx), {24'd0, collisions}, {24'd0, v.ecoll});
        $display("vec %0d: ack=%0b wen=%0b waddr=%h din=%h rdsel=%0b rdata=%h coll=%0d",
                 idx, spi_ack, ram_write_en, ram_addr_w, ram_din, ram_rd_sel, spi_rdata, collisions);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got_ack;
        logic [7:0] exp_coll;

        // zr za zd | sr sw sa sd | ack wen wa wd rd rdata coll
        vecs[0]  = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0123, 8'hA5, 1, 1, 14'h0123, 8'hA5, 0, 8'h00, 8'd0);
        vecs[1]  = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0123, 8'hA5, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 8'd0);
        vecs[2]  = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0123, 8'hA5, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 8'd0);
        vecs[3]  = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0123, 8'hA5, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 8'd0);
        vecs[4]  = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0124, 8'h3C, 1, 1, 14'h0124, 8'h3C, 0, 8'h00, 8'd0);
        vecs[5]  = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0124, 8'h3C, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 8'd0);
        vecs[6]  = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0124, 8'h3C, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 8'd0);
        // contention: Z80 first, SPI write next cycle, one collision
        vecs[7]  = mkv(1, 14'h0200, 8'h11, 1, 1, 14'h0300, 8'h22, 0, 1, 14'h0200, 8'h11, 0, 8'h00, 8'd1);
        vecs[8]  = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0300, 8'h22, 1, 1, 14'h0300, 8'h22, 0, 8'h00, 8'd1);
        vecs[9]  = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0300, 8'h22, 0, 0, 14'h0000, 8'h00, 0, 8'h00, 8'd1);
        // Z80 preloads RAM[0x0040]=0x5A
        vecs[10] = mkv(1, 14'h0040, 8'h5A, 0, 0, 14'h0000, 8'h00, 0, 1, 14'h0040, 8'h5A, 0, 8'h00, 8'd1);
        // SPI read of 0x0040
        vecs[11] = mkv(0, 14'h0000, 8'h00, 1, 0, 14'h0040, 8'h00, 0, 0, 14'h0000, 8'h00, 1, 8'h00, 8'd1);
        vecs[12] = mkv(0, 14'h0000, 8'h00, 1, 0, 14'h0040, 8'h00, 1, 0, 14'h0000, 8'h00, 1, 8'h5A, 8'd1);
        vecs[13] = mkv(0, 14'h0000, 8'h00, 1, 0, 14'h0040, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        vecs[14] = mkv(0, 14'h0000, 8'h00, 0, 0, 14'h0040, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        // Z80 write arriving while the SPI transfer sits in REL
        vecs[15] = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0500, 8'h66, 1, 1, 14'h0500, 8'h66, 0, 8'h5A, 8'd1);
        vecs[16] = mkv(1, 14'h0600, 8'h77, 1, 1, 14'h0500, 8'h66, 0, 1, 14'h0600, 8'h77, 0, 8'h5A, 8'd1);
        vecs[17] = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0500, 8'h66, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        // req dropped during SWR: ack still emitted, REL left at once
        vecs[18] = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0700, 8'h88, 1, 1, 14'h0700, 8'h88, 0, 8'h5A, 8'd1);
        vecs[19] = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0700, 8'h88, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        vecs[20] = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0700, 8'h88, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        vecs[21] = mkv(0, 14'h0000, 8'h00, 1, 1, 14'h0701, 8'h99, 1, 1, 14'h0701, 8'h99, 0, 8'h5A, 8'd1);
        vecs[22] = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0701, 8'h99, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        vecs[23] = mkv(0, 14'h0000, 8'h00, 0, 1, 14'h0701, 8'h99, 0, 0, 14'h0000, 8'h00, 0, 8'h5A, 8'd1);
        // Z80 write and SPI read of 0x0124 in adjacent cycles: old data returned
        vecs[24] = mkv(1, 14'h0124, 8'hC3, 1, 0, 14'h0124, 8'h00, 0, 1, 14'h0124, 8'hC3, 1, 8'h5A, 8'd1);
        vecs[25] = mkv(0, 14'h0000, 8'h00, 1, 0, 14'h0124, 8'h00, 1, 0, 14'h0000, 8'h00, 1, 8'h3C, 8'd1);
        vecs[26] = mkv(0, 14'h0000, 8'h00, 0, 0, 14'h0124, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 8'h3C, 8'd1);
        vecs[27] = mkv(0, 14'h0000, 8'h00, 0, 0, 14'h0124, 8'h00, 0, 0, 14'h0000, 8'h00, 0, 8'h3C, 8'd1);

        // ---------------- reset with a pending request ----------------
        rst_n = 1'b0;
        z80_wr_req = 1'b0; z80_wr_addr = '0; z80_wr_data = '0; z80_mreq_n = 1'b1;
        spi_req = 1'b1; spi_we = 1'b1; spi_addr = 14'h0010; spi_wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ack", {31'd0, spi_ack}, 32'd0);
            check("rst_wen", {31'd0, ram_write_en}, 32'd0);
            check("rst_rdsel", {31'd0, ram_rd_sel}, 32'd0);
            check("rst_coll", {24'd0, collisions}, 32'd0);
            check("rst_rdata", {24'd0, spi_rdata}, 32'd0);
            $display("reset cycle %0d: ack=%0b wen=%0b rdsel=%0b coll=%0d", i, spi_ack, ram_write_en, ram_rd_sel, collisions);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ack", {31'd0, spi_ack}, 32'd1);
        check("post_rst_wen", {31'd0, ram_write_en}, 32'd1);
        check("post_rst_waddr", {18'd0, ram_addr_w}, 32'h0010);
        check("post_rst_wdata", {24'd0, ram_din}, 32'h77);
        $display("post-reset write: ack=%0b wen=%0b waddr=%h din=%h", spi_ack, ram_write_en, ram_addr_w, ram_din);
        @(negedge clk);
        spi_req = 1'b0;
        step();
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 28; i++) apply_vec(vecs[i], i);

        // ---------------- read aborted by MREQ ----------------
        @(negedge clk);
        spi_req = 1'b1; spi_we = 1'b0; spi_addr = 14'h0123; z80_mreq_n = 1'b0;
        step();
        check("abort_radr_rdsel", {31'd0, ram_rd_sel}, 32'd1);
        check("abort_radr_ack", {31'd0, spi_ack}, 32'd0);
        step();
        check("abort_rdsel_drop", {31'd0, ram_rd_sel}, 32'd0);
        check("abort_noack", {31'd0, spi_ack}, 32'd0);
        check("abort_coll", {24'd0, collisions}, 32'd2);
        $display("read abort: rdsel=%0b ack=%0b coll=%0d", ram_rd_sel, spi_ack, collisions);
        for (int i = 0; i < 3; i++) begin
            step();
            check("busy_wait_rdsel", {31'd0, ram_rd_sel}, 32'd0);
            check("busy_wait_coll", {24'd0, collisions}, 32'd2);
        end
        @(negedge clk);
        z80_mreq_n = 1'b1;
        got_ack = 0;
        for (int i = 0; i < 10 && got_ack == 0; i++) begin
            step();
            if (spi_ack) got_ack = 1;
        end
        check("retry_ack_seen", got_ack, 32'd1);
        check("retry_rdata", {24'd0, spi_rdata}, 32'hA5);
        check("retry_coll", {24'd0, collisions}, 32'd2);
        $display("read retry: ack_seen=%0d rdata=%h coll=%0d", got_ack, spi_rdata, collisions);
        @(negedge clk);
        spi_req = 1'b0;
        step();
        step();

        // ---------------- 300 forced write contentions ----------------
        exp_coll = 8'd2;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            z80_wr_req = 1'b1; z80_wr_addr = 14'h1000 + 14'(i); z80_wr_data = 8'(i);
            spi_req = 1'b1; spi_we = 1'b1; spi_addr = 14'h2000 + 14'(i); spi_wdata = ~8'(i);
            step();
            if (exp_coll != 8'hFF) exp_coll = exp_coll + 8'd1;
            check("sat_z80_wen", {31'd0, ram_write_en}, 32'd1);
            check("sat_z80_waddr", {18'd0, ram_addr_w}, {18'd0, 14'h1000 + 14'(i)});
            check("sat_coll", {24'd0, collisions}, {24'd0, exp_coll});
            @(negedge clk);
            z80_wr_req = 1'b0;
            step();
            check("sat_spi_ack", {31'd0, spi_ack}, 32'd1);
            check("sat_spi_waddr", {18'd0, ram_addr_w}, {18'd0, 14'h2000 + 14'(i)});
            check("sat_spi_wdata", {24'd0, ram_din}, {24'd0, ~8'(i)});
            @(negedge clk);
            spi_req = 1'b0;
            step();
            step();
            $display("contention %0d: coll=%0d", i, collisions);
        end
        check("sat_final", {24'd0, collisions}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
